// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: shared widths, arbiter state and FIFO entry type
package regfile_wb_arbiter_pkg;
    localparam int REG_W = 5;
    localparam int XLEN  = 32;
    typedef enum logic {ARB, DRAIN} arb_state_e;
    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  data;
    } md_entry_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback, mul/div and register-file port signals
interface regfile_wb_arbiter_if;
    import regfile_wb_arbiter_pkg::*;
    logic             WbValid;
    logic [REG_W-1:0] WbRd;
    logic [XLEN-1:0]  WbData;
    logic             MdValid;
    logic [REG_W-1:0] MdRd;
    logic [XLEN-1:0]  MdData;
    logic             MdReady;
    logic             RegWriteEn;
    logic [REG_W-1:0] RegWriteAddr;
    logic [XLEN-1:0]  RegWriteData;
    logic             PipeStall;
    logic [XLEN-1:0]  RdBusy;
    modport master (
        output WbValid, WbRd, WbData, MdValid, MdRd, MdData,
        input  MdReady, RegWriteEn, RegWriteAddr, RegWriteData, PipeStall, RdBusy
    );
    modport slave (
        input  WbValid, WbRd, WbData, MdValid, MdRd, MdData,
        output MdReady, RegWriteEn, RegWriteAddr, RegWriteData, PipeStall, RdBusy
    );
endinterface

// File: rtl/regfile_wb_arbiter_fifo.sv
// wb_result_fifo: mul/div result queue with per-entry valid bits for the busy mask
module wb_result_fifo
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_push,
    input  logic            i_pop,
    input  md_entry_t       i_entry,
    output md_entry_t       o_head,
    output logic            o_full,
    output logic            o_empty,
    output logic [XLEN-1:0] o_busy
);
    localparam int PTR_W = $clog2(DEPTH);
    md_entry_t        r_mem [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic [XLEN-1:0]  w_busy;
    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = r_count == (PTR_W+1)'(DEPTH);
    assign o_empty = r_count == '0;
    assign o_busy  = w_busy;
    // Pointers, occupancy and valid bits; clear on pop before set on push
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_pop) begin
                r_rd_ptr          <= r_rd_ptr + PTR_W'(1);
                r_valid[r_rd_ptr] <= 1'b0;
            end
            if (i_push) begin
                r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
                r_valid[r_wr_ptr] <= 1'b1;
            end
            r_count <= r_count + (PTR_W+1)'(i_push) - (PTR_W+1)'(i_pop);
        end
    end
    // Entry storage needs no reset; valid bits gate every use
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_entry;
    end
    // Destination mask of every queued entry; x0 is never reported
    always_comb begin
        w_busy = '0;
        for (int i = 0; i < DEPTH; i++)
            if (r_valid[i]) w_busy[r_mem[i].rd] = 1'b1;
        w_busy[0] = 1'b0;
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between writeback and mul/div results
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input logic                 clk,
    input logic                 rst,
    regfile_wb_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
    arb_state_e       r_state;
    arb_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_starve;
    logic [CNT_W-1:0] w_starve_nxt;
    logic [CNT_W-1:0] w_starve_inc;
    logic             w_wb_req;
    logic             w_wb_win;
    logic             w_lost;
    logic             w_hit;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    md_entry_t        w_head;
    logic [XLEN-1:0]  w_busy;
    assign w_wb_req = bus.WbValid && bus.WbRd != '0;
    assign w_wb_win = r_state == ARB && w_wb_req;
    assign w_pop    = !w_empty && !w_wb_win;
    assign w_lost   = w_wb_win && !w_empty;
    assign w_push   = bus.MdValid && !w_full && bus.MdRd != '0;
    assign bus.MdReady      = !w_full;
    assign bus.PipeStall    = r_state == DRAIN;
    assign bus.RdBusy       = w_busy;
    assign bus.RegWriteEn   = w_wb_win || w_pop;
    assign bus.RegWriteAddr = w_wb_win ? bus.WbRd : w_head.rd;
    assign bus.RegWriteData = w_wb_win ? bus.WbData : w_head.data;
    wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_entry ('{rd: bus.MdRd, data: bus.MdData}),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_busy  (w_busy)
    );
    // Arbiter state and starvation count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ARB;
            r_starve <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_starve <= w_starve_nxt;
        end
    end
    // Forced drain once the head has lost STARVE_LIMIT arbitrations in a row; DRAIN lasts one cycle
    always_comb begin
        w_starve_inc = r_starve + CNT_W'(1);
        w_hit        = w_lost && w_starve_inc == LIMIT;
        w_state_nxt  = w_hit ? DRAIN : ARB;
        w_starve_nxt = (w_lost && !w_hit) ? w_starve_inc : '0;
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed checks of port arbitration, forced drain and reset
module tb_regfile_wb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_err = 0;
    int   n_chk = 0;
    regfile_wb_arbiter_if bus();
    regfile_wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic exp_cyc(input string tag, input logic st, input logic [4:0] a,
                           input logic [31:0] d, input logic rdy);
        #1;
        chk({tag, ".stall"}, 32'(bus.PipeStall), 32'(st));
        chk({tag, ".en"}, 32'(bus.RegWriteEn), 32'd1);
        chk({tag, ".addr"}, 32'(bus.RegWriteAddr), 32'(a));
        chk({tag, ".data"}, bus.RegWriteData, d);
        chk({tag, ".ready"}, 32'(bus.MdReady), 32'(rdy));
        cyc();
    endtask
    task automatic md(input logic v, input logic [4:0] r, input logic [31:0] d);
        bus.MdValid = v;
        bus.MdRd    = r;
        bus.MdData  = d;
    endtask
    task automatic wb(input logic v, input logic [4:0] r, input logic [31:0] d);
        bus.WbValid = v;
        bus.WbRd    = r;
        bus.WbData  = d;
    endtask
    task automatic fill_to_drain(input string tag);
        wb(1, 3, 32'hAA);
        md(1, 10, 32'hA0);
        exp_cyc({tag, ".c0"}, 0, 3, 32'hAA, 1);
        md(1, 11, 32'hB0);
        exp_cyc({tag, ".c1"}, 0, 3, 32'hAA, 1);
        md(1, 12, 32'hC0);
        #1 chk({tag, ".busy_full"}, bus.RdBusy, 32'h0000_0C00);
        exp_cyc({tag, ".c2"}, 0, 3, 32'hAA, 0);
        exp_cyc({tag, ".c3"}, 0, 3, 32'hAA, 0);
        exp_cyc({tag, ".c4"}, 0, 3, 32'hAA, 0);
    endtask
    initial begin
        wb(0, 0, 0);
        md(0, 0, 0);
        #1;
        chk("rst.stall", 32'(bus.PipeStall), 0);
        chk("rst.ready", 32'(bus.MdReady), 1);
        chk("rst.busy", bus.RdBusy, 0);
        chk("rst.en", 32'(bus.RegWriteEn), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cyc();
        md(1, 5, 32'h1234);
        #1 chk("idle.nobypass", 32'(bus.RegWriteEn), 0);
        cyc();
        md(0, 0, 0);
        #1;
        chk("idle.en", 32'(bus.RegWriteEn), 1);
        chk("idle.addr", 32'(bus.RegWriteAddr), 5);
        chk("idle.data", bus.RegWriteData, 32'h1234);
        chk("idle.busy", bus.RdBusy, 32'h20);
        cyc();
        #1;
        chk("idle.busy_clr", bus.RdBusy, 0);
        chk("idle.en_clr", 32'(bus.RegWriteEn), 0);
        cyc();
        wb(1, 3, 32'hAA);
        md(1, 7, 32'h77);
        exp_cyc("prio.c0", 0, 3, 32'hAA, 1);
        md(0, 0, 0);
        for (int i = 0; i < 4; i++) exp_cyc("prio.wb", 0, 3, 32'hAA, 1);
        exp_cyc("prio.drain", 1, 7, 32'h77, 1);
        #1 chk("prio.busy_clr", bus.RdBusy, 0);
        exp_cyc("prio.after", 0, 3, 32'hAA, 1);
        wb(0, 0, 0);
        md(1, 9, 32'h99);
        cyc();
        md(0, 0, 0);
        wb(1, 0, 32'hDEAD);
        exp_cyc("x0.head", 0, 9, 32'h99, 1);
        wb(0, 0, 0);
        md(1, 0, 32'h55);
        #1 chk("x0.md_en", 32'(bus.RegWriteEn), 0);
        chk("x0.md_ready", 32'(bus.MdReady), 1);
        cyc();
        md(0, 0, 0);
        #1 chk("x0.md_drop_en", 32'(bus.RegWriteEn), 0);
        chk("x0.md_drop_busy", bus.RdBusy, 0);
        cyc();
        wb(1, 2, 32'h22);
        md(1, 8, 32'h88);
        exp_cyc("sim.q", 0, 2, 32'h22, 1);
        wb(0, 0, 0);
        md(1, 4, 32'h44);
        #1 chk("sim.busy8", bus.RdBusy, 32'h100);
        exp_cyc("sim.pop8", 0, 8, 32'h88, 1);
        md(0, 0, 0);
        #1 chk("sim.busy4", bus.RdBusy, 32'h10);
        exp_cyc("sim.pop4", 0, 4, 32'h44, 1);
        #1 chk("sim.busy_clr", bus.RdBusy, 0);
        cyc();
        fill_to_drain("full");
        exp_cyc("full.c5", 1, 10, 32'hA0, 0);
        exp_cyc("full.c6", 0, 3, 32'hAA, 1);
        md(0, 0, 0);
        for (int i = 0; i < 3; i++) exp_cyc("full.c7_9", 0, 3, 32'hAA, 0);
        exp_cyc("full.c10", 1, 11, 32'hB0, 0);
        for (int i = 0; i < 4; i++) exp_cyc("full.c11_14", 0, 3, 32'hAA, 1);
        exp_cyc("full.c15", 1, 12, 32'hC0, 1);
        #1 chk("full.busy_clr", bus.RdBusy, 0);
        exp_cyc("full.c16", 0, 3, 32'hAA, 1);
        fill_to_drain("ar");
        #1 chk("ar.stall_pre", 32'(bus.PipeStall), 1);
        rst = 1'b1;
        md(0, 0, 0);
        #1;
        chk("ar.stall", 32'(bus.PipeStall), 0);
        chk("ar.busy", bus.RdBusy, 0);
        chk("ar.ready", 32'(bus.MdReady), 1);
        wb(0, 0, 0);
        #1 chk("ar.en", 32'(bus.RegWriteEn), 0);
        rst = 1'b0;
        cyc();
        #1;
        chk("ar.post_en", 32'(bus.RegWriteEn), 0);
        chk("ar.post_stall", 32'(bus.PipeStall), 0);
        chk("ar.post_busy", bus.RdBusy, 0);
        cyc();
        #1 chk("ar.post_en2", 32'(bus.RegWriteEn), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Arbitrates the single register-file write port between the in-order writeback stage and the multi-cycle multiply/divide unit. Mul/div results are accepted over a valid/ready handshake into a small FIFO. They drain through write-port slots the writeback stage leaves idle. A starvation counter forces a one-cycle pipeline stall when the FIFO has waited too long. The block sits between writeback, the mul/div unit and the register file, and exports a busy mask to the hazard unit.

## Interface
- DEPTH, 2: mul/div result FIFO entries (power of two, ≥2)
- STARVE_LIMIT, 4: consecutive lost arbitrations before a forced drain (≥1)
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- WbValid  in  1  writeback stage requests a register write (its RegWriteOut)
- WbRd  in  5  writeback destination
- WbData  in  32  writeback data
- MdValid  in  1  mul/div result valid
- MdRd  in  5  mul/div destination
- MdData  in  32  mul/div result
- MdReady  out  1  FIFO can accept (= not full)
- RegWriteEn  out  1  register-file write enable
- RegWriteAddr  out  5  register-file write address
- RegWriteData  out  32  register-file write data
- PipeStall  out  1  registered; pipeline must hold its WB-stage contents
- RdBusy  out  32  bit r set while any FIFO entry targets r; bit 0 always 0

## Operation
- Effective WB request: WbValid && WbRd != 0. A write to x0 never uses the port.
- Push: MdValid && MdReady. Entries with MdRd == 0 are handshaken and then dropped, never enqueued.
- FSM states:
  - ARB: an effective WB request wins the port. Otherwise the FIFO head is written and popped if the FIFO is non-empty.
  - DRAIN: the WB request is ignored. The FIFO head is written and popped.
- Starvation counter:
  - Increments on each ARB cycle where the FIFO is non-empty and WB wins.
  - Clears on any pop, and whenever the FIFO is empty.
- ARB→DRAIN: on the clock edge where the counter reaches STARVE_LIMIT. The counter clears on that edge.
- DRAIN→ARB: unconditionally after one cycle.
- PipeStall = (state == DRAIN). WB holds its request stable and retries the next cycle.
- Write-port mux is combinational from current inputs and the FIFO head. No direct bypass: a pushed entry is writable at the earliest one cycle later.
- Push and pop in the same cycle are allowed at any occupancy. MdReady depends on registered occupancy only, so a full FIFO refuses a push even while popping.
- RdBusy = OR over valid entries of onehot(rd). It is combinational from FIFO state and drops in the cycle after the last matching entry pops.
- WAW ordering between WB and FIFO entries is not resolved here. The hazard unit stalls on RdBusy.

## Timing
- Reset values (async, immediate): FIFO empty, counter 0, state ARB, PipeStall 0, MdReady 1, RdBusy 0. RegWriteEn = effective WB request, so it is 0 while WbValid = 0.
- Reset mid-DRAIN or with a full FIFO: all entries are lost and PipeStall deasserts without waiting for a clock.
- Latency, push to register-file write: ≥1 cycle. It is exactly 1 if the port is idle the next cycle.
- Worst case with WB saturating the port and a full FIFO: each entry is written within STARVE_LIMIT+1 cycles of reaching the head.
- Full FIFO with MdValid held: MdReady = 0 and there is no push. The unit keeps MdValid and data stable until accepted.
- Pointers wrap modulo DEPTH. Occupancy counter is log2(DEPTH)+1 bits.

## Structure
- Shared package: the register-index width (5), XLEN (32) and the FSM enum {ARB, DRAIN}.
- Natural sub-module: `wb_result_fifo` (DEPTH × {rd, data}, push/pop, full/empty, per-entry valid for RdBusy).
- The arbiter FSM and starvation counter live in the top module.

## Test plan
- Idle port:
  - Stimulus: push MdRd=5, MdData=0x1234 with WbValid=0.
  - Response: next cycle RegWriteEn=1, Addr=5, Data=0x1234. RdBusy[5] is 1 for exactly that one cycle.
- WB priority:
  - Stimulus: WbValid=1, WbRd=3, WbData=0xAA every cycle; one FIFO entry rd=7.
  - Response: writes to 3 for 4 cycles, then PipeStall=1 and a write of rd=7. The following cycle writes 3 again.
- Full FIFO:
  - Stimulus: DEPTH=2, WB saturating, push two entries.
  - Response: MdReady=0. A third MdValid is held until the forced pop. FIFO order is preserved.
- x0 handling:
  - Stimulus: WbValid=1, WbRd=0 with a FIFO entry rd=9 queued.
  - Response: rd=9 written that cycle, with no starvation increment. MdRd=0 pushes never assert RegWriteEn.
- Simultaneous push and pop:
  - Stimulus: one entry queued, WB idle, push rd=4.
  - Response: head written, rd=4 enqueued, occupancy stays 1.
- Async reset:
  - Stimulus: assert rst mid-DRAIN with the FIFO full.
  - Response: PipeStall, RdBusy and occupancy reach 0 before the next edge, MdReady=1, and no spurious write occurs after reset.
